// File: rtl/lmsm_sequencer_if.sv
// Memory-port and register-file-port bundle between the LM/SM sequencer (master)
// and the memory / register file it drives (slave).
interface lmsm_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int REG_AW = 3
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic [REG_AW-1:0] rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, rf_raddr, rf_we, rf_waddr, rf_wdata,
    input  mem_rdata, mem_ready, rf_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, rf_raddr, rf_we, rf_waddr, rf_wdata,
    output mem_rdata, mem_ready, rf_rdata
  );
endinterface

// File: rtl/lmsm_sequencer.sv
// Load-multiple / store-multiple engine: one register<->memory transfer per accepted memory cycle.
// Latency: N set mask bits -> N RUN cycles (mem_ready high) + 1 DONE cycle.
// Backpressure: mem_ready low freezes every output and register until the access is accepted.
module lmsm_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int NREGS  = 8,
  parameter int REG_AW = $clog2(NREGS),
  parameter int CNT_W  = $clog2(NREGS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_store,
  input  logic              dir,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [NREGS-1:0]  mask,
  output logic              busy,
  output logic              stall_req,
  output logic              done,
  output logic [CNT_W-1:0]  xfer_count,
  lmsm_sequencer_if.master  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [NREGS-1:0]   rem_q;
  logic [NREGS-1:0]   rem_clr;
  logic               store_q;
  logic               dir_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [REG_AW-1:0]  idx;

  // Last hit wins: scanning down finds the lowest set bit, scanning up the highest.
  always_comb begin
    idx = '0;
    if (dir_q) begin
      for (int i = 0; i < NREGS; i++)
        if (rem_q[i]) idx = REG_AW'(i);
    end else begin
      for (int i = NREGS - 1; i >= 0; i--)
        if (rem_q[i]) idx = REG_AW'(i);
    end
  end

  assign rem_clr = rem_q & ~(NREGS'(1) << idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    busy        = 1'b0;
    done        = 1'b0;
    bus.mem_req = 1'b0;
    bus.mem_we  = 1'b0;
    bus.rf_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (mask == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        busy        = 1'b1;
        bus.mem_req = 1'b1;
        bus.mem_we  = store_q;
        if (bus.mem_ready) begin
          bus.rf_we = !store_q;
          if (rem_clr == '0) state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Address and mode are frozen at start, so loading the base register mid-op is harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      rem_q   <= '0;
      store_q <= 1'b0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_q  <= base_addr;
            rem_q   <= mask;
            store_q <= is_store;
            dir_q   <= dir;
            cnt_q   <= '0;
          end
        end
        S_RUN: begin
          if (bus.mem_ready) begin
            rem_q  <= rem_clr;
            addr_q <= dir_q ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
            cnt_q  <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign stall_req     = busy | (start & (state_q == S_IDLE));
  assign xfer_count    = cnt_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = bus.rf_rdata;
  assign bus.rf_raddr  = idx;
  assign bus.rf_waddr  = idx;
  assign bus.rf_wdata  = bus.mem_rdata;

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Bench for lmsm_sequencer: memory/register-file environment, transfer-list reference model,
// per-cycle output comparison, directed scenarios and randomized operations.
module tb_lmsm_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic        dir = 1'b0;
  logic [15:0] base_addr = '0;
  logic [7:0]  mask = '0;
  logic        busy, stall_req, done;
  logic [3:0]  xfer_count;

  lmsm_sequencer_if #(.DATA_W(16), .ADDR_W(16), .REG_AW(3)) bus ();

  lmsm_sequencer #(.DATA_W(16), .ADDR_W(16), .NREGS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_store  (is_store),
    .dir       (dir),
    .base_addr (base_addr),
    .mask      (mask),
    .busy      (busy),
    .stall_req (stall_req),
    .done      (done),
    .xfer_count(xfer_count),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // ---------------- environment: memory, register file, ready driver ----------------
  logic [15:0] mem [0:65535];
  logic [15:0] rf  [0:7];
  bit          mem_init = 1'b0;
  logic        ld_mem = 1'b0, ld_rf = 1'b0;
  logic [15:0] ld_addr = '0, ld_data = '0;
  int          rf_wr_cnt = 0;
  int          rdy_mode = 0;
  int          wait_cnt = 0;

  assign bus.mem_rdata = mem[bus.mem_addr];
  assign bus.rf_rdata  = rf[bus.rf_raddr];

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
      mem_init = 1'b1;
    end
    if (ld_mem) mem[ld_addr] = ld_data;
    if (ld_rf) for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
    if (bus.mem_req && bus.mem_ready && bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
    if (bus.rf_we) begin
      rf[bus.rf_waddr] = bus.rf_wdata;
      rf_wr_cnt++;
    end
  end

  initial bus.mem_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1: bus.mem_ready = ($urandom_range(0, 2) != 0);
      2: begin
        if (bus.mem_req && wait_cnt < 2) begin
          bus.mem_ready = 1'b0;
          wait_cnt++;
        end else begin
          bus.mem_ready = 1'b1;
          wait_cnt = 0;
        end
      end
      default: bus.mem_ready = 1'b1;
    endcase
  end

  // ---------------- reference model: list of pending transfers ----------------
  typedef struct {
    logic [15:0] addr;
    int          r;
    bit          we;
  } xfer_t;

  xfer_t m_q[$];
  bit    m_active = 1'b0;
  int    m_count = 0;
  int    mk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 1'b0;
      m_q.delete();
      m_count = 0;
    end else if (!m_active) begin
      if (start) begin
        m_q.delete();
        m_count  = 0;
        m_active = 1'b1;
        mk = 0;
        if (!dir) begin
          for (int i = 0; i < 8; i++)
            if (mask[i]) begin
              m_q.push_back('{addr: base_addr + 16'(mk), r: i, we: is_store});
              mk++;
            end
        end else begin
          for (int i = 7; i >= 0; i--)
            if (mask[i]) begin
              m_q.push_back('{addr: base_addr - 16'(mk), r: i, we: is_store});
              mk++;
            end
        end
      end
    end else if (m_q.size() > 0) begin
      if (bus.mem_ready) begin
        void'(m_q.pop_front());
        m_count++;
      end
    end else begin
      m_active = 1'b0;
    end
  end

  // ---------------- checking ----------------
  int n_tests = 0, n_fail = 0;
  int done_cnt = 0, busy_cyc = 0, stall_cyc = 0, req_cyc = 0, we_cyc = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    bit    exp_req, exp_rfwe;
    xfer_t h;
    exp_req = m_active && (m_q.size() > 0);
    h = exp_req ? m_q[0] : '{addr: 16'h0, r: 0, we: 1'b0};
    check("busy",       32'(busy),           32'(m_active));
    check("done",       32'(done),           32'(m_active && m_q.size() == 0));
    check("xfer_count", 32'(xfer_count),     32'(m_count));
    check("stall_req",  32'(stall_req),      32'(m_active || start));
    check("mem_req",    32'(bus.mem_req),    32'(exp_req));
    if (exp_req) begin
      check("mem_addr", 32'(bus.mem_addr), 32'(h.addr));
      check("mem_we",   32'(bus.mem_we),   32'(h.we));
      check("rf_raddr", 32'(bus.rf_raddr), 32'(h.r));
      if (h.we) check("mem_wdata", 32'(bus.mem_wdata), 32'(rf[h.r]));
    end
    exp_rfwe = exp_req && bus.mem_ready && !h.we;
    check("rf_we", 32'(bus.rf_we), 32'(exp_rfwe));
    if (exp_rfwe) begin
      check("rf_waddr", 32'(bus.rf_waddr), 32'(h.r));
      check("rf_wdata", 32'(bus.rf_wdata), 32'(mem[h.addr]));
    end
  endtask

  task automatic do_start(input bit st, input bit d, input logic [15:0] b, input logic [7:0] m);
    @(posedge clk); #1;
    start = 1'b1; is_store = st; dir = d; base_addr = b; mask = m;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    bit seen;
    d0 = done_cnt;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(posedge clk);
      if (done_cnt > d0) seen = 1'b1;
    end
    #1;
    check("done_within_budget", 32'(seen), 32'd1);
  endtask

  task automatic load_rf();
    ld_rf = 1'b1;
    @(posedge clk); #1;
    ld_rf = 1'b0;
  endtask

  task automatic load_mem(input logic [15:0] a, input logic [15:0] d);
    ld_addr = a; ld_data = d; ld_mem = 1'b1;
    @(posedge clk); #1;
    ld_mem = 1'b0;
  endtask

  logic [15:0] r0, r1, r2, xa[8], xv[8];
  int          xr[8];
  bit          xw[8];
  int          nx, d0, b0, s0, q0, w0, f0, c;
  bit          st, dd;
  logic [15:0] bb;
  logic [7:0]  mm;

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          done_cnt  += 32'(done);
          busy_cyc  += 32'(busy);
          stall_cyc += 32'(stall_req);
          req_cyc   += 32'(bus.mem_req);
          we_cyc    += 32'(bus.mem_we);
          compare_cycle();
        end
      end
    join_none

    #1 rst = 1'b1;
    #1;
    check("rst_busy",       32'(busy),        32'd0);
    check("rst_done",       32'(done),        32'd0);
    check("rst_mem_req",    32'(bus.mem_req), 32'd0);
    check("rst_rf_we",      32'(bus.rf_we),   32'd0);
    check("rst_xfer_count", 32'(xfer_count),  32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // LM ascending
    load_rf();
    load_mem(16'h0040, 16'hA0A1);
    load_mem(16'h0041, 16'hB0B1);
    load_mem(16'h0042, 16'hC0C1);
    load_mem(16'h0043, 16'hD0D1);
    r1 = rf[1];
    q0 = req_cyc; b0 = busy_cyc;
    do_start(1'b0, 1'b0, 16'h0040, 8'b1010_0101);
    wait_done(50);
    check("lma_r0", 32'(rf[0]), 32'h0000_A0A1);
    check("lma_r2", 32'(rf[2]), 32'h0000_B0B1);
    check("lma_r5", 32'(rf[5]), 32'h0000_C0C1);
    check("lma_r7", 32'(rf[7]), 32'h0000_D0D1);
    check("lma_r1_untouched", 32'(rf[1]), 32'(r1));
    check("lma_run_cycles", 32'(req_cyc - q0), 32'd4);
    check("lma_busy_cycles", 32'(busy_cyc - b0), 32'd5);
    check("lma_xfer_count", 32'(xfer_count), 32'd4);

    // SM descending
    load_rf();
    r0 = rf[0]; r1 = rf[1]; r2 = rf[2];
    w0 = we_cyc;
    do_start(1'b1, 1'b1, 16'h0107, 8'b0000_0111);
    wait_done(50);
    check("smd_107", 32'(mem[16'h0107]), 32'(r2));
    check("smd_106", 32'(mem[16'h0106]), 32'(r1));
    check("smd_105", 32'(mem[16'h0105]), 32'(r0));
    check("smd_we_cycles", 32'(we_cyc - w0), 32'd3);

    // empty mask
    q0 = req_cyc; s0 = stall_cyc; d0 = done_cnt;
    do_start(1'b0, 1'b0, 16'h1234, 8'h00);
    wait_done(20);
    check("m0_req_cycles", 32'(req_cyc - q0), 32'd0);
    check("m0_stall_cycles", 32'(stall_cyc - s0), 32'd2);
    check("m0_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("m0_xfer_count", 32'(xfer_count), 32'd0);

    // address wrap under backpressure
    rdy_mode = 2;
    load_rf();
    r0 = rf[0]; r1 = rf[1];
    b0 = busy_cyc;
    do_start(1'b1, 1'b0, 16'hFFFF, 8'b0000_0011);
    wait_done(50);
    check("wrap_ffff", 32'(mem[16'hFFFF]), 32'(r0));
    check("wrap_0000", 32'(mem[16'h0000]), 32'(r1));
    check("wrap_busy_cycles", 32'(busy_cyc - b0), 32'd7);
    rdy_mode = 0;

    // base register in mask, second start while busy
    load_rf();
    load_mem(16'h0020, 16'h1111);
    load_mem(16'h0021, 16'h2222);
    load_mem(16'h0022, 16'h3333);
    w0 = rf_wr_cnt; d0 = done_cnt;
    do_start(1'b0, 1'b0, 16'h0020, 8'b0011_1000);
    start = 1'b1; is_store = 1'b1; base_addr = 16'h0300; mask = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(50);
    repeat (3) @(posedge clk);
    #1;
    check("bo_r3", 32'(rf[3]), 32'h0000_1111);
    check("bo_r4", 32'(rf[4]), 32'h0000_2222);
    check("bo_r5", 32'(rf[5]), 32'h0000_3333);
    check("bo_rf_writes", 32'(rf_wr_cnt - w0), 32'd3);
    check("bo_done_pulses", 32'(done_cnt - d0), 32'd1);

    // reset in the middle of an LM
    load_rf();
    w0 = rf_wr_cnt; f0 = done_cnt;
    do_start(1'b0, 1'b0, 16'h0200, 8'hFF);
    c = 0;
    while (m_count < 3 && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    check("rr_reached_3", 32'(m_count), 32'd3);
    #1 rst = 1'b1;
    #1;
    check("rr_busy_async", 32'(busy), 32'd0);
    check("rr_mem_req_async", 32'(bus.mem_req), 32'd0);
    check("rr_rf_we_async", 32'(bus.rf_we), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rr_rf_writes", 32'(rf_wr_cnt - w0), 32'd3);
    check("rr_no_done", 32'(done_cnt - f0), 32'd0);
    check("rr_xfer_count", 32'(xfer_count), 32'd0);

    // randomized operations
    for (int t = 0; t < 40; t++) begin
      rdy_mode = $urandom_range(0, 1);
      load_rf();
      st = 1'($urandom_range(0, 1));
      dd = 1'($urandom_range(0, 1));
      bb = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 7)) : 16'($urandom);
      mm = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      do_start(st, dd, bb, mm);
      nx = m_q.size();
      check("rnd_list_len", 32'(nx), 32'($countones(mm)));
      for (int j = 0; j < nx && j < 8; j++) begin
        xa[j] = m_q[j].addr;
        xr[j] = m_q[j].r;
        xw[j] = m_q[j].we;
        xv[j] = m_q[j].we ? rf[m_q[j].r] : mem[m_q[j].addr];
      end
      wait_done(200);
      check("rnd_xfer_count", 32'(xfer_count), 32'(nx));
      for (int j = 0; j < nx && j < 8; j++) begin
        if (xw[j]) check("rnd_mem", 32'(mem[xa[j]]), 32'(xv[j]));
        else       check("rnd_rf",  32'(rf[xr[j]]),  32'(xv[j]));
      end
    end
    rdy_mode = 0;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
